// File: rtl/prio_enc_hs.sv
// prio_enc_hs -- registered N-to-log2(N) priority encoder with sticky request
// capture and a valid/ack handshake.
//
// Request bits are latched into a pending mask (pend). The selected pending
// index is presented on A with valid. Each ack retires the granted index. The
// next pending index is presented on the following cycle, so there is no
// bubble between grants.
//
// Build option:
//   ROUND_ROBIN_EN  defined   : the search runs downward from a rotating
//                               pointer and wraps around.
//                   undefined : fixed priority, with index N-1 highest.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   en     request capture enable (when 0, req is ignored)
//   req    [N-1:0] request lines, level or pulse
//   ack    consumer accepts A; ignored while valid=0
//   A      [W-1:0] registered index of the granted request
//   valid  registered; A holds a pending request
//   pend   [N-1:0] registered pending mask, including the granted bit
module prio_enc_hs #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] req,
  input  logic         ack,
  output logic [W-1:0] A,
  output logic         valid,
  output logic [N-1:0] pend
);

  typedef enum logic {IDLE, HOLD} state_t;
  state_t state;

  logic [N-1:0] newreq, p_eff, p_rem, a_oh;
  logic [W-1:0] sel_eff, sel_rem;

  always_comb begin
    newreq = en ? req : '0;
    p_eff  = pend | newreq;
    a_oh   = N'(1) << A;
    // A new request on the bit being cleared wins, so the bit stays pending.
    p_rem  = (pend & ~a_oh) | newreq;
  end

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr;
  logic [W-1:0] a_m1;

  // The first set bit among start, start-1, ..., 0, N-1, ... wins.
  // The loop overwrites the result, so the smallest distance from start is
  // the one that is kept.
  function automatic logic [W-1:0] sel_rr(input logic [N-1:0] x,
                                          input logic [W-1:0] start);
    logic [W-1:0] idx, c;
    idx = '0;
    for (int d = N - 1; d >= 0; d--) begin
      c = start - W'(d);
      if (x[c]) idx = c;
    end
    return idx;
  endfunction

  always_comb begin
    a_m1    = A - W'(1);
    sel_eff = sel_rr(p_eff, ptr);
    // On an ack, the pointer moves to A-1 on this same edge. The follow-on
    // grant must therefore search from the new position.
    sel_rem = sel_rr(p_rem, a_m1);
  end
`else
  // Fixed priority. The highest set index wins.
  function automatic logic [W-1:0] sel_fix(input logic [N-1:0] x);
    logic [W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++)
      if (x[i]) idx = W'(i);
    return idx;
  endfunction

  always_comb begin
    sel_eff = sel_fix(p_eff);
    sel_rem = sel_fix(p_rem);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      A     <= '0;
      valid <= 1'b0;
`ifdef ROUND_ROBIN_EN
      ptr   <= W'(N - 1);
`endif
    end else if (state == IDLE) begin
      pend <= p_eff;
      if (|p_eff) begin
        A     <= sel_eff;
        valid <= 1'b1;
        state <= HOLD;
      end
    end else begin
      if (ack) begin
        pend <= p_rem;
`ifdef ROUND_ROBIN_EN
        ptr  <= a_m1;
`endif
        if (|p_rem) begin
          A <= sel_rem;
        end else begin
          // A keeps its last value on the way back to IDLE.
          valid <= 1'b0;
          state <= IDLE;
        end
      end else begin
        // While a grant is held, A is frozen. New requests only accumulate.
        pend <= p_eff;
      end
    end
  end

endmodule

// File: tb/tb_prio_enc_hs.sv
// Testbench for prio_enc_hs.
// The stimulus process drives inputs on the falling edge. It advances a
// behavioural model of the pending set and the grant, and pushes the expected
// outputs for the next rising edge into a queue. The monitor process pops one
// entry after each rising edge and compares it with the DUT outputs.
module tb_prio_enc_hs;
  localparam int N = 4;
  localparam int W = 2;
`ifdef ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         ack = 1'b0;
  logic [N-1:0] req = '0;
  logic [W-1:0] A;
  logic         valid;
  logic [N-1:0] pend;

  always #5 clk = ~clk;

  prio_enc_hs #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .ack(ack),
    .A(A), .valid(valid), .pend(pend)
  );

  typedef struct packed {
    logic [W-1:0] a;
    logic         v;
    logic [N-1:0] p;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: the set of pending indices, the granted index,
  // the grant flag and the round-robin start point.
  bit mp[N];
  int mg   = 0;
  bit mv   = 1'b0;
  int mptr = N - 1;

  // Return the first pending index in the search order.
  // Fixed priority searches N-1, N-2, ..., 0.
  // Round robin searches start, start-1, ..., 0, N-1, ... with wrap-around.
  function automatic int pick(input int start);
    int i;
    for (int d = 0; d < N; d++) begin
      i = RR ? (start - d + N) % N : N - 1 - d;
      if (mp[i]) return i;
    end
    return 0;
  endfunction

  task automatic cyc(input logic r, input logic e, input logic [N-1:0] q,
                     input logic k);
    exp_t x;
    bit   any;
    @(negedge clk);
    rst = r; en = e; req = q; ack = k;
    if (r) begin
      for (int i = 0; i < N; i++) mp[i] = 1'b0;
      mg = 0; mv = 1'b0; mptr = N - 1;
    end else begin
      if (mv && k) begin
        mp[mg] = 1'b0;
        mptr = (mg + N - 1) % N;
      end
      for (int i = 0; i < N; i++)
        if (e && q[i]) mp[i] = 1'b1;
      if (!mv || k) begin
        any = 1'b0;
        for (int i = 0; i < N; i++) any |= mp[i];
        if (any) begin
          mg = pick(mptr);
          mv = 1'b1;
        end else begin
          mv = 1'b0;
        end
      end
    end
    x.a = W'(mg);
    x.v = mv;
    for (int i = 0; i < N; i++) x.p[i] = mp[i];
    exp_q.push_back(x);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (A !== e.a || valid !== e.v || pend !== e.p) begin
          errors++;
          $display("FAIL outputs t=%0t A=%0d valid=%b pend=%b expected A=%0d valid=%b pend=%b",
                   $time, A, valid, pend, e.a, e.v, e.p);
        end
      end
    end
  end

  // Stimulus
  initial begin
    // Reset is held for 2 cycles while every other input is active.
    cyc(1, 1, 4'b1111, 1);
    cyc(1, 1, 4'b1111, 1);
    cyc(0, 1, 4'b1111, 0);
    repeat (5) cyc(0, 1, 4'b0000, 1);

    // Capture disable, then enable.
    repeat (3) cyc(0, 0, 4'b0100, 0);
    cyc(0, 1, 4'b0100, 0);
    cyc(0, 1, 4'b0000, 1);
    cyc(0, 1, 4'b0000, 0);

    // Single grant held for 5 cycles, then acked.
    cyc(0, 1, 4'b0010, 0);
    repeat (5) cyc(0, 1, 4'b0000, 0);
    cyc(0, 1, 4'b0000, 1);
    cyc(0, 1, 4'b0000, 0);

    // Back-to-back drain.
    cyc(0, 1, 4'b1011, 1);
    repeat (4) cyc(0, 1, 4'b0000, 1);

    // A higher-priority request arrives while a grant is held.
    cyc(0, 1, 4'b1011, 0);
    cyc(0, 1, 4'b0000, 1);
    cyc(0, 1, 4'b1000, 0);
    repeat (3) cyc(0, 1, 4'b0000, 0);
    repeat (5) cyc(0, 1, 4'b0000, 1);

    // Request and clear on the same bit in one cycle.
    cyc(0, 1, 4'b1000, 0);
    cyc(0, 1, 4'b1000, 1);
    cyc(0, 1, 4'b0000, 0);
    repeat (2) cyc(0, 1, 4'b0000, 1);

    // All requests held with ack held (round-robin wrap in the RR build).
    repeat (8) cyc(0, 1, 4'b1111, 1);
    repeat (5) cyc(0, 1, 4'b0000, 1);

    // Randomized traffic, including mid-operation resets.
    for (int n = 0; n < 3000; n++) begin
      logic [N-1:0] q;
      q = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0), q,
          ($urandom_range(0, 1) == 1));
    end
    cyc(1, 0, 4'b0000, 0);

    // Give the monitor time to consume the last entry.
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain left=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/prio_enc_hs.md
Name: prio_enc_hs

Overview:
- Registered N-to-log2(N) priority encoder with sticky request capture and a valid/ack handshake. It is the encoding counterpart of the 2-to-4 decoder block.
- One-hot or multi-hot request lines are latched into a pending mask. The highest-priority pending index is presented on A with valid.
- Each ack retires that index; the next pending index follows with no bubble cycle.
- Sits between request sources (interrupt lines, channel flags) and a consumer that drives a dec_2_to_4-style decoder from A.

Parameters:
- N, 4, number of request lines (power of two, at least 2).
- W, 2, encoded index width; must equal log2(N).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- en, input, 1, request capture enable; when 0, new req bits are ignored.
- req, input, N, request lines; level or pulse; bit i requests index i.
- ack, input, 1, consumer accepts the current A; honoured only while valid=1.
- A, output, W, encoded index of the granted request (registered).
- valid, output, 1, A holds a pending request (registered).
- pend, output, N, pending mask P (registered), including the bit currently granted.

Behaviour:
- Single clock domain (clk); reset is synchronous and active-high on rst. All outputs are registered.
- Reset: P=0, A=0, valid=0, state IDLE, RR pointer=N-1. Reset overrides all other inputs on that edge.
- Definitions:
  - newreq = en ? req : 0
  - P_eff = P | newreq
  - sel(X) = highest set index of X (fixed priority, index N-1 highest)
  - onehot(A) = the N-bit mask with only bit A set
- State IDLE (valid=0):
  - If P_eff != 0: A<=sel(P_eff), valid<=1, go to HOLD.
  - Always P<=P_eff.
  - Latency: a req bit at edge k gives valid=1 and pend updated after edge k.
- State HOLD (valid=1):
  - ack=0: A and valid are held stable. P<=P_eff, so new requests accumulate without changing A, even if they are higher priority.
  - ack=1: compute P_rem=(P & ~onehot(A)) | newreq, then P<=P_rem.
    - If P_rem != 0: A<=sel(P_rem), valid stays 1, stay in HOLD. This gives back-to-back grants at 1 per cycle.
    - If P_rem == 0: valid<=0, go to IDLE. A keeps its last value.
- ack while valid=0 has no effect.
- Duplicate request for an already-pending bit merges into that bit; there is no count and no overflow.
- Request and clear on the same bit in one cycle: the request wins, so the bit stays pending and can be re-granted on the next grant.
- en=0 blocks capture only; already pending bits still drain through the handshake.
- Reset mid-operation discards all pending bits and any outstanding grant; valid=0 on the next cycle.

Optional Feature:
- Macro: ROUND_ROBIN_EN.
- Defined:
  - sel() searches downward from pointer ptr with wrap-around. The first set bit among ptr, ptr-1, ..., 0, N-1, ... wins.
  - On each accepted ack of index k, ptr<=(k-1) mod N. Reset sets ptr=N-1.
  - A continuously re-asserted index cannot starve the others.
- Not defined: fixed priority (index N-1 highest). No pointer register is synthesised.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: rst=1 for 2 cycles with en=1, req=4'b1111, ack=1 -> valid=0, A=2'b00, pend=4'b0000 throughout. After release, valid=1 with A=2'b11 on the first edge.
- Capture disable: en=0, req=4'b0100 for 3 cycles -> valid=0, pend=4'b0000. Then en=1, req=4'b0100 for 1 cycle -> valid=1, A=2'b10, pend=4'b0100.
- Single grant: req=4'b0010 pulse, no ack for 5 cycles -> A=2'b01, valid=1 held stable. Then ack for 1 cycle -> valid=0, pend=4'b0000.
- Back-to-back drain: req=4'b1011 single pulse, ack held high -> A=11, 01, 00 on consecutive cycles with valid=1, then valid=0, pend=0. A higher-priority req=4'b1000 arriving while A=2'b01 is held without ack leaves A unchanged; that bit shows in pend.
- Same-cycle request and clear: in HOLD with A=2'b11, pend=4'b1000, assert req=4'b1000 and ack=1 -> valid stays 1, A=2'b11, pend=4'b1000.
- ROUND_ROBIN_EN: req=4'b1111 held, ack held -> A=11, 10, 01, 00, 11 (wraps). Without the macro the same stimulus gives A=11 every cycle.
